// File: rtl/rapid_pkg.sv
// Shared RAPID core types: decoded control word, opcode constants and immediate formats.
package rapid_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic       load_upper_imm;
        logic       uncond_branch;
        logic       cond_branch;
        logic       mem;
        logic       alu_imm;
        logic       alu_reg;
        logic       iop;
        logic       mul;
        logic [2:0] fcs_opcode;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rs1_out;
        logic       rs2_out;
        logic       rd_we;
        logic       illegal;
    } control_s;

    // 32-bit sign-extended immediate for the given encoding format.
    function automatic logic [31:0] imm32(input logic [31:0] inst, input imm_fmt_e fmt);
        logic [31:0] imm;
        imm = '0;
        case (fmt)
            IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U: imm = {inst[31:12], 12'b0};
            IMM_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_fifo.sv
// Synchronous {instruction, pc} buffer with wrap-around pointers and an occupancy count.
module decode_fifo
    import rapid_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned XLEN       = 32
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_clear,
    input  logic                        i_push,
    input  logic [31:0]                 i_instruction,
    input  logic [XLEN-1:0]             i_pc,
    input  logic                        i_pop,
    output logic [31:0]                 o_instruction,
    output logic [XLEN-1:0]             o_pc,
    output logic [$clog2(FIFO_DEPTH):0] o_count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      inst_mem [FIFO_DEPTH];
    logic [XLEN-1:0]  pc_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (i_push) wr_ptr <= ptr_next(wr_ptr);
            if (i_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({i_push, i_pop})
                2'b10:   o_count <= o_count + CNT_W'(1);
                2'b01:   o_count <= o_count - CNT_W'(1);
                default: o_count <= o_count;
            endcase
        end
    end

    // Storage needs no reset; pointers define which entries are live.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            inst_mem[wr_ptr] <= i_instruction;
            pc_mem[wr_ptr]   <= i_pc;
        end
    end

    assign o_instruction = inst_mem[rd_ptr];
    assign o_pc          = pc_mem[rd_ptr];

endmodule

// File: rtl/decode_stage.sv
// Elastic RV32I decode stage: input FIFO with empty-bypass feeding a registered decode output.
module decode_stage
    import rapid_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter bit          EN_M_EXT   = 1'b0
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [31:0]                 i_instruction,
    input  logic [XLEN-1:0]             i_pc,
    input  logic                        i_flush,
    output logic                        o_valid,
    input  logic                        i_ready,
    output control_s                    o_control_signal,
    output logic [XLEN-1:0]             o_imm,
    output logic [XLEN-1:0]             o_pc,
    output logic                        o_illegal,
    output logic [$clog2(FIFO_DEPTH):0] o_count
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        control_s        ctrl;
        logic [XLEN-1:0] imm;
    } decoded_s;

    logic            accept;
    logic            load;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            src_valid;
    logic [31:0]     fifo_inst;
    logic [XLEN-1:0] fifo_pc;
    logic [31:0]     src_inst;
    logic [XLEN-1:0] src_pc;
    decoded_s        dec;

    function automatic decoded_s decode(input logic [31:0] inst);
        decoded_s   d;
        imm_fmt_e   fmt;
        logic       illegal;
        logic [2:0] f3;
        logic [6:0] f7;
        d       = '0;
        fmt     = IMM_NONE;
        illegal = 1'b0;
        f3      = inst[14:12];
        f7      = inst[31:25];
        case (inst[6:0])
            OPC_LUI: begin
                d.ctrl.load_upper_imm = 1'b1;
                d.ctrl.rd             = inst[11:7];
                d.ctrl.rd_we          = 1'b1;
                fmt                   = IMM_U;
            end
            OPC_AUIPC: begin
                d.ctrl.load_upper_imm = 1'b1;
                d.ctrl.iop            = 1'b1;
                d.ctrl.rd             = inst[11:7];
                d.ctrl.rd_we          = 1'b1;
                fmt                   = IMM_U;
            end
            OPC_JAL: begin
                d.ctrl.uncond_branch = 1'b1;
                d.ctrl.iop           = 1'b1;
                d.ctrl.rd            = inst[11:7];
                d.ctrl.rd_we         = 1'b1;
                fmt                  = IMM_J;
            end
            OPC_JALR: begin
                d.ctrl.uncond_branch = 1'b1;
                d.ctrl.fcs_opcode    = f3;
                d.ctrl.rs1           = inst[19:15];
                d.ctrl.rs1_out       = 1'b1;
                d.ctrl.rd            = inst[11:7];
                d.ctrl.rd_we         = 1'b1;
                fmt                  = IMM_I;
                illegal              = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                d.ctrl.cond_branch = 1'b1;
                d.ctrl.fcs_opcode  = f3;
                d.ctrl.rs1         = inst[19:15];
                d.ctrl.rs2         = inst[24:20];
                d.ctrl.rs1_out     = 1'b1;
                d.ctrl.rs2_out     = 1'b1;
                fmt                = IMM_B;
                illegal            = (f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                d.ctrl.mem        = 1'b1;
                d.ctrl.fcs_opcode = f3;
                d.ctrl.rs1        = inst[19:15];
                d.ctrl.rs1_out    = 1'b1;
                d.ctrl.rd         = inst[11:7];
                d.ctrl.rd_we      = 1'b1;
                fmt               = IMM_I;
                illegal           = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                d.ctrl.mem        = 1'b1;
                d.ctrl.iop        = 1'b1;
                d.ctrl.fcs_opcode = f3;
                d.ctrl.rs1        = inst[19:15];
                d.ctrl.rs2        = inst[24:20];
                d.ctrl.rs1_out    = 1'b1;
                d.ctrl.rs2_out    = 1'b1;
                fmt               = IMM_S;
                illegal           = (f3 > 3'b010);
            end
            OPC_OP_IMM: begin
                d.ctrl.alu_imm    = 1'b1;
                d.ctrl.iop        = (f3 == 3'b101) && inst[30];
                d.ctrl.fcs_opcode = f3;
                d.ctrl.rs1        = inst[19:15];
                d.ctrl.rs1_out    = 1'b1;
                d.ctrl.rd         = inst[11:7];
                d.ctrl.rd_we      = 1'b1;
                fmt               = IMM_I;
                // Shift amounts only occupy imm[4:0]; the upper field selects logical/arithmetic.
                if (f3 == 3'b001)      illegal = (f7 != F7_BASE);
                else if (f3 == 3'b101) illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
            end
            OPC_OP: begin
                d.ctrl.alu_reg    = 1'b1;
                d.ctrl.iop        = inst[30];
                d.ctrl.mul        = (f7 == F7_MULDIV);
                d.ctrl.fcs_opcode = f3;
                d.ctrl.rs1        = inst[19:15];
                d.ctrl.rs2        = inst[24:20];
                d.ctrl.rs1_out    = 1'b1;
                d.ctrl.rs2_out    = 1'b1;
                d.ctrl.rd         = inst[11:7];
                d.ctrl.rd_we      = 1'b1;
                if (f7 == F7_BASE)        illegal = 1'b0;
                else if (f7 == F7_ALT)    illegal = (f3 != 3'b000) && (f3 != 3'b101);
                else if (f7 == F7_MULDIV) illegal = !EN_M_EXT;
                else                      illegal = 1'b1;
            end
            OPC_MISC_MEM: begin
                illegal = 1'b0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (d.ctrl.rd == 5'd0) d.ctrl.rd_we = 1'b0;
        d.imm = XLEN'($signed(imm32(inst, fmt)));
        if (illegal) begin
            d              = '0;
            d.ctrl.illegal = 1'b1;
        end
        return d;
    endfunction

    assign o_ready = !i_reset && (o_count < CNT_W'(FIFO_DEPTH));

    // Handshake steering: bypass the FIFO only when it is empty and the output can load.
    always_comb begin
        accept     = i_valid && o_ready;
        fifo_empty = (o_count == '0);
        load       = !o_valid || i_ready;
        src_valid  = !fifo_empty || accept;
        pop        = load && !fifo_empty;
        push       = accept && !(load && fifo_empty);
        src_inst   = fifo_empty ? i_instruction : fifo_inst;
        src_pc     = fifo_empty ? i_pc : fifo_pc;
        dec        = decode(src_inst);
    end

    decode_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .XLEN       (XLEN)
    ) u_fifo (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_clear       (i_flush),
        .i_push        (push),
        .i_instruction (i_instruction),
        .i_pc          (i_pc),
        .i_pop         (pop),
        .o_instruction (fifo_inst),
        .o_pc          (fifo_pc),
        .o_count       (o_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            o_valid          <= 1'b0;
            o_control_signal <= '0;
            o_imm            <= '0;
            o_pc             <= '0;
            o_illegal        <= 1'b0;
        end else if (load) begin
            o_valid <= src_valid;
            if (src_valid) begin
                o_control_signal <= dec.ctrl;
                o_imm            <= dec.imm;
                o_pc             <= src_pc;
                o_illegal        <= dec.ctrl.illegal;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: two instances (M-ext off/on) against a behavioural decoder model.
module tb_decode_stage;
    import rapid_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        control_s    ctrl;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        ill;
    } exp_s;

    logic            i_clk;
    logic            i_reset;
    logic            i_valid;
    logic [31:0]     i_instruction;
    logic [XLEN-1:0] i_pc;
    logic            i_flush;
    logic            i_ready;

    logic             o_ready, o_valid, o_illegal;
    control_s         o_control_signal;
    logic [XLEN-1:0]  o_imm, o_pc;
    logic [CNT_W-1:0] o_count;

    logic             m_ready, m_valid, m_illegal;
    control_s         m_control_signal;
    logic [XLEN-1:0]  m_imm, m_pc;
    logic [CNT_W-1:0] m_count;

    int   vectors     = 0;
    int   miscompares = 0;
    int   dut_acc     = 0;
    bit   chk_en      = 0;
    bit   rst_pending = 0;
    exp_s q0[$];
    exp_s q1[$];

    decode_stage #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .EN_M_EXT(1'b0)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_instruction(i_instruction), .i_pc(i_pc), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_control_signal(o_control_signal),
        .o_imm(o_imm), .o_pc(o_pc), .o_illegal(o_illegal), .o_count(o_count)
    );

    decode_stage #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .EN_M_EXT(1'b1)) dut_m (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(m_ready),
        .i_instruction(i_instruction), .i_pc(i_pc), .i_flush(i_flush),
        .o_valid(m_valid), .i_ready(i_ready), .o_control_signal(m_control_signal),
        .o_imm(m_imm), .o_pc(m_pc), .o_illegal(m_illegal), .o_count(m_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference decoder: fields from operand usage sets, immediates by integer arithmetic.
    function automatic exp_s ref_model(input logic [31:0] w, input logic [31:0] pc, input bit en_m);
        exp_s       e;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         u1, u2, ud, uf, ok;
        int         imm;
        int         sw;
        e = '0; u1 = 0; u2 = 0; ud = 0; uf = 0; ok = 1; imm = 0;
        f3 = w[14:12];
        f7 = w[31:25];
        sw = $signed(w);
        case (w[6:0])
            7'b0110111: begin e.ctrl.load_upper_imm = 1; ud = 1; imm = int'(w & 32'hFFFF_F000); end
            7'b0010111: begin e.ctrl.load_upper_imm = 1; e.ctrl.iop = 1; ud = 1; imm = int'(w & 32'hFFFF_F000); end
            7'b1101111: begin
                e.ctrl.uncond_branch = 1; e.ctrl.iop = 1; ud = 1;
                imm = (sw >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            end
            7'b1100111: begin e.ctrl.uncond_branch = 1; u1 = 1; ud = 1; uf = 1; imm = sw >>> 20; ok = (f3 == 0); end
            7'b1100011: begin
                e.ctrl.cond_branch = 1; u1 = 1; u2 = 1; uf = 1;
                imm = (sw >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
                ok = !(f3 inside {3'd2, 3'd3});
            end
            7'b0000011: begin e.ctrl.mem = 1; u1 = 1; ud = 1; uf = 1; imm = sw >>> 20; ok = !(f3 inside {3'd3, 3'd6, 3'd7}); end
            7'b0100011: begin
                e.ctrl.mem = 1; e.ctrl.iop = 1; u1 = 1; u2 = 1; uf = 1;
                imm = (sw >>> 25) * 32 + int'(w[11:7]); ok = (f3 <= 3'd2);
            end
            7'b0010011: begin
                e.ctrl.alu_imm = 1; e.ctrl.iop = (f3 == 3'd5) && w[30]; u1 = 1; ud = 1; uf = 1; imm = sw >>> 20;
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                else if (f3 == 3'd5) ok = (f7 inside {7'h00, 7'h20});
            end
            7'b0110011: begin
                e.ctrl.alu_reg = 1; e.ctrl.iop = w[30]; u1 = 1; u2 = 1; ud = 1; uf = 1;
                if (f7 == 7'h00) ok = 1;
                else if (f7 == 7'h20) ok = (f3 inside {3'd0, 3'd5});
                else if (f7 == 7'h01) begin ok = en_m; e.ctrl.mul = 1; end
                else ok = 0;
            end
            7'b0001111: ok = 1;
            default:    ok = 0;
        endcase
        e.ctrl.fcs_opcode = uf ? f3 : 3'd0;
        e.ctrl.rs1     = u1 ? w[19:15] : 5'd0;
        e.ctrl.rs2     = u2 ? w[24:20] : 5'd0;
        e.ctrl.rd      = ud ? w[11:7] : 5'd0;
        e.ctrl.rs1_out = u1;
        e.ctrl.rs2_out = u2;
        e.ctrl.rd_we   = ud && (w[11:7] != 5'd0);
        e.imm = 32'(imm);
        e.pc  = pc;
        if (!ok) begin
            e.ctrl = '0;
            e.ctrl.illegal = 1;
            e.imm = '0;
            e.ill = 1;
        end
        return e;
    endfunction

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input logic v, input logic [CNT_W-1:0] cnt, input logic rdy,
                             input control_s c, input logic [31:0] imm, input logic [31:0] pc,
                             input logic ill, input exp_s front, input int n);
        int exp_cnt;
        exp_cnt = (n > 0) ? n - 1 : 0;
        cmp({tag, ".o_valid"}, 64'(v), 64'(n > 0));
        cmp({tag, ".o_count"}, 64'(cnt), 64'(exp_cnt));
        cmp({tag, ".o_ready"}, 64'(rdy), 64'(!i_reset && (n <= int'(DEPTH))));
        if (v === 1'b1 && n > 0) begin
            cmp({tag, ".ctrl"}, 64'(c), 64'(front.ctrl));
            cmp({tag, ".imm"}, 64'(imm), 64'(front.imm));
            cmp({tag, ".pc"}, 64'(pc), 64'(front.pc));
            cmp({tag, ".illegal"}, 64'(ill), 64'(front.ill));
        end
        if (rst_pending) begin
            cmp({tag, ".rst_ctrl"}, 64'(c), 64'(0));
            cmp({tag, ".rst_imm"}, 64'(imm), 64'(0));
            cmp({tag, ".rst_pc"}, 64'(pc), 64'(0));
            cmp({tag, ".rst_ill"}, 64'(ill), 64'(0));
        end
    endtask

    // Monitor: check presented state, then advance the model for the coming edge.
    always @(negedge i_clk) begin
        int   n;
        bit   acc;
        exp_s f0, f1;
        n  = q0.size();
        f0 = (n > 0) ? q0[0] : '0;
        f1 = (n > 0) ? q1[0] : '0;
        if (chk_en) begin
            check_dut("dut", o_valid, o_count, o_ready, o_control_signal, o_imm, o_pc, o_illegal, f0, n);
            check_dut("dut_m", m_valid, m_count, m_ready, m_control_signal, m_imm, m_pc, m_illegal, f1, n);
        end
        if (i_valid && o_ready) dut_acc++;
        rst_pending = i_reset;
        if (i_reset || i_flush) begin
            q0.delete();
            q1.delete();
        end else begin
            acc = i_valid && (n <= int'(DEPTH));
            if (n > 0 && i_ready) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (acc) begin
                q0.push_back(ref_model(i_instruction, i_pc, 1'b0));
                q1.push_back(ref_model(i_instruction, i_pc, 1'b1));
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 13);
        case (sel)
            0:  w[6:0] = 7'b0110111;
            1:  w[6:0] = 7'b0010111;
            2:  w[6:0] = 7'b1101111;
            3:  w[6:0] = 7'b1100111;
            4:  w[6:0] = 7'b1100011;
            5:  w[6:0] = 7'b0000011;
            6:  w[6:0] = 7'b0100011;
            7:  w[6:0] = 7'b0010011;
            8:  w[6:0] = 7'b0001111;
            9, 10: begin
                w[6:0] = 7'b0110011;
                case ($urandom_range(0, 3))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    2: w[31:25] = 7'h01;
                    default: ;
                endcase
            end
            11: begin
                w[6:0] = 7'b0010011;
                w[13:12] = 2'b01;
                w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            end
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        i_reset = 1; i_valid = 0; i_ready = 1; i_flush = 0; i_instruction = '0; i_pc = '0;
        step();
        chk_en = 1;
        repeat (2) step();
        i_reset = 0;

        // ADDI x1,x0,-1 with one-cycle latency
        i_valid = 1; i_instruction = 32'hFFF0_0093; i_pc = 32'h100;
        step();
        cmp("addi.valid", 64'(o_valid), 64'(1));
        cmp("addi.alu_imm", 64'(o_control_signal.alu_imm), 64'(1));
        cmp("addi.rd", 64'(o_control_signal.rd), 64'(1));
        cmp("addi.rd_we", 64'(o_control_signal.rd_we), 64'(1));
        cmp("addi.imm", 64'(o_imm), 64'h0000_0000_FFFF_FFFF);
        cmp("addi.pc", 64'(o_pc), 64'h100);

        i_instruction = 32'h4041_D113; i_pc = 32'h104;
        step();
        cmp("srai.iop", 64'(o_control_signal.iop), 64'(1));
        cmp("srai.fcs", 64'(o_control_signal.fcs_opcode), 64'(5));
        cmp("srai.imm", 64'(o_imm), 64'h404);

        i_instruction = 32'hFE20_8EE3; i_pc = 32'h108;
        step();
        cmp("beq.cond", 64'(o_control_signal.cond_branch), 64'(1));
        cmp("beq.imm", 64'(o_imm), 64'h0000_0000_FFFF_FFFC);
        cmp("beq.rs1", 64'(o_control_signal.rs1), 64'(1));
        cmp("beq.rs2", 64'(o_control_signal.rs2), 64'(2));
        cmp("beq.rd_we", 64'(o_control_signal.rd_we), 64'(0));
        i_valid = 0;
        step();

        // Backpressure: five offered, three held
        i_ready = 0; dut_acc = 0;
        for (int k = 0; k < 5; k++) begin
            i_valid = 1; i_instruction = 32'h0000_0093 | (32'(k + 1) << 20) | (32'(k + 1) << 7);
            i_pc = 32'h200 + 32'(4 * k);
            step();
        end
        i_valid = 0;
        cmp("bp.accepted", 64'(dut_acc), 64'(3));
        cmp("bp.o_ready", 64'(o_ready), 64'(0));
        i_ready = 1;
        repeat (4) step();

        // Illegal encodings
        i_valid = 1; i_instruction = 32'h0000_0000; i_pc = 32'h300;
        step();
        cmp("zero.illegal", 64'(o_illegal), 64'(1));
        cmp("zero.imm", 64'(o_imm), 64'(0));
        i_instruction = 32'h0220_8033; i_pc = 32'h304;
        step();
        cmp("mul.illegal_noext", 64'(o_illegal), 64'(1));
        cmp("mul.illegal_ext", 64'(m_illegal), 64'(0));
        cmp("mul.mul_ext", 64'(m_control_signal.mul), 64'(1));
        cmp("mul.alu_reg_ext", 64'(m_control_signal.alu_reg), 64'(1));
        i_valid = 0;
        step();

        // Flush with a full buffer and a concurrent offer
        i_ready = 0;
        for (int k = 0; k < 3; k++) begin
            i_valid = 1; i_instruction = gen_inst(); i_pc = 32'h400 + 32'(4 * k);
            step();
        end
        i_instruction = 32'h0010_0113; i_flush = 1;
        step();
        i_flush = 0; i_valid = 0;
        cmp("flush.o_valid", 64'(o_valid), 64'(0));
        cmp("flush.o_count", 64'(o_count), 64'(0));
        i_ready = 1;
        repeat (4) step();

        // Reset while holding output under backpressure
        i_ready = 0;
        for (int k = 0; k < 2; k++) begin
            i_valid = 1; i_instruction = gen_inst(); i_pc = 32'h500 + 32'(4 * k);
            step();
        end
        i_valid = 0;
        cmp("mid.o_valid_before", 64'(o_valid), 64'(1));
        i_reset = 1;
        step();
        cmp("mid.o_valid", 64'(o_valid), 64'(0));
        cmp("mid.o_pc", 64'(o_pc), 64'(0));
        cmp("mid.o_count", 64'(o_count), 64'(0));
        i_reset = 0; i_ready = 1; i_valid = 1; i_instruction = 32'hFFF0_0093; i_pc = 32'h600;
        step();
        cmp("post_rst.o_valid", 64'(o_valid), 64'(1));
        cmp("post_rst.o_pc", 64'(o_pc), 64'h600);

        // Randomised traffic with occasional flush and reset
        for (int k = 0; k < 3000; k++) begin
            i_valid       = ($urandom_range(0, 3) != 0);
            i_ready       = ($urandom_range(0, 3) != 0);
            i_flush       = ($urandom_range(0, 49) == 0);
            i_reset       = ($urandom_range(0, 299) == 0);
            i_instruction = gen_inst();
            i_pc          = i_pc + 32'd4;
            step();
        end
        i_valid = 0; i_ready = 1; i_flush = 0; i_reset = 0;
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, elastic RV32I decode stage for the RAPID core. It sits between fetch and register-read/execute. Raw instruction/PC pairs enter through a valid/ready handshake and are buffered in a small FIFO. Each pair is decoded to `control_s` plus a sign-extended immediate and held in an output register with its own valid/ready handshake. The stage adds full legality checking, optional M-extension decode and pipeline flush, and sustains one instruction per cycle.

## Interface
- `XLEN`, 32: datapath width; immediates sign-extend to `XLEN`.
- `FIFO_DEPTH`, 2: input buffer entries (≥1, power of two).
- `EN_M_EXT`, 0: 1 decodes MUL/DIV (funct7=0000001); 0 flags them illegal.

- `i_clk`  in  1  clock
- `i_reset`  in  1  synchronous, active-high reset
- `i_valid`  in  1  upstream instruction valid
- `o_ready`  out  1  stage can accept: `!i_reset && count<FIFO_DEPTH`
- `i_instruction`  in  32  raw instruction
- `i_pc`  in  XLEN  instruction address
- `i_flush`  in  1  discard all buffered and output instructions
- `o_valid`  out  1  decoded instruction valid
- `i_ready`  in  1  downstream accepts
- `o_control_signal`  out  `control_s`  decoded control
- `o_imm`  out  XLEN  signed immediate
- `o_pc`  out  XLEN  PC of decoded instruction
- `o_illegal`  out  1  instruction is illegal/unsupported
- `o_count`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- **Accept and advance.**
  - Accept on `i_valid && o_ready`.
  - The output register loads when `!o_valid || i_ready`, and `o_valid` updates at the same edge.
  - Source is the FIFO head if the FIFO is non-empty.
  - Otherwise the source is the incoming instruction (bypass). The FIFO is not written in that case.
  - Ordering is strictly preserved.
- **Opcodes.** LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, MISC-MEM 0001111 (FENCE decodes to all-zero control, legal).
- **Block flags and `iop`.**
  - `load_upper_imm`: `iop`=1 for AUIPC.
  - `uncond_branch`: `iop`=1 for JAL.
  - `cond_branch`.
  - `mem`: `iop`=1 for store.
  - `alu_imm`: `iop`=inst[30] only when funct3=101, else 0.
  - `alu_reg`: `iop`=inst[30]; `mul`=1 for M-ext.
- **Register fields.**
  - `fcs_opcode`=inst[14:12] for all formats with funct3, else 0.
  - `rs1`/`rs2`/`rd` are taken from the standard fields only when the format uses them; otherwise 0.
  - `rs1_out`/`rs2_out`/`rd_we` are set per format.
  - `rd_we`=0 when rd=0.
- **Immediates.** Formats I/S/B/U/J per the ISA, sign-extended to `XLEN`. B and J have bit 0 = 0. Zero for R-type.
- **Illegal.** Any of the following is illegal:
  - inst[1:0]≠11, or an unknown opcode;
  - JALR funct3≠0;
  - BRANCH funct3 010/011;
  - LOAD funct3 011/110/111;
  - STORE funct3>010;
  - shift-immediate imm[11:5] not 0000000/0100000 (0100000 only with funct3=101);
  - OP funct7 not 0000000/0100000 (0100000 only with funct3 000/101);
  - funct7 0000001 with `EN_M_EXT`=0.
- **Handling illegal instructions.** All control fields and `o_imm` are forced to 0, `o_illegal`=1, and `o_pc` is valid. The instruction still handshakes normally.

## Timing
- **Reset.**
  - Takes effect at the next edge; the FIFO empties.
  - `o_valid`=0, `o_control_signal`=all-zero, `o_imm`=0, `o_pc`=0, `o_illegal`=0, `o_count`=0.
  - `o_ready`=0 while reset is asserted and 1 in the first cycle after.
  - A reset arriving mid-stream discards everything; no partial output is ever presented.
- **Latency.** 1 cycle with empty FIFO and free output. Otherwise 1 cycle after reaching the FIFO head.
- **Throughput.** 1/cycle when `i_ready`=1 continuously.
- **Full.** `o_ready`=0 at `count`=`FIFO_DEPTH`. Simultaneous pop and push at full is not permitted: `o_ready` is registered-count based.
- **Empty.** Bypass applies with no bubble.
- **`o_valid` stability.** Held until `i_ready`; outputs stable while `o_valid && !i_ready`.
- **Flush.**
  - `i_flush` at edge N clears the FIFO and `o_valid`.
  - An accept in the same cycle is dropped; flush wins.
  - Reset has priority over flush.

## Structure
- `rapid_pkg` gains:
  - `control_s` fields `rd_we`, `mul`, `illegal`;
  - 7-bit opcode localparams written as `7'b` literals;
  - an `imm_fmt_e` enum (I,S,B,U,J,NONE).
- Sub-module `decode_fifo` is a synchronous FIFO of {instruction, pc}, parametrised by `FIFO_DEPTH` and `XLEN`, with wrap-around pointers and a count.
- Decode is a pure function inside `decode_stage`.

## Test plan
- **ADDI.** 0xFFF00093 (ADDI x1,x0,-1) at pc 0x100, i_ready=1 → next cycle o_valid=1, alu_imm=1, rd=1, rd_we=1, rs1=0, imm=0xFFFFFFFF, iop=0, o_pc=0x100.
- **SRAI and BEQ.** 0x4041D113 (SRAI x2,x3,4) → iop=1, fcs_opcode=101, imm=0x404. 0xFE208EE3 (BEQ x1,x2,-4) → cond_branch=1, imm=0xFFFFFFFC, rs1=1, rs2=2, rd_we=0.
- **Backpressure.** FIFO_DEPTH=2, i_ready=0, stream 5 instructions → exactly 3 accepted and o_ready=0. Release i_ready → 3 outputs on consecutive cycles, in order.
- **Illegal.** 0x00000000 → o_illegal=1, all control fields 0. 0x02208033 (MUL) → illegal with EN_M_EXT=0; with EN_M_EXT=1 → alu_reg=1, mul=1, o_illegal=0.
- **Flush.** i_flush with i_valid=1 and 2 entries buffered → next cycle o_valid=0, o_count=0, and no buffered instruction ever emerges.
- **Reset mid-stream.** i_reset while o_valid=1, i_ready=0 → all outputs at reset values next cycle. The first post-reset instruction decodes with 1-cycle latency.
